pc_unit: RTL and testbench

Parametrised program-counter unit for the pipelined core. It replaces the plain enable-gated PC register with on-chip next-PC selection: sequential, PC-relative branch, absolute jump, call and return. It includes a hardware return-address stack (RAS). It sits at the head of the fetch stage, drives the imem address and consumes redirect commands from execute.

---
 rtl/pc_pkg.sv | 15 +
 rtl/pc_unit_if.sv | 29 ++
 rtl/pc_ras.sv | 48 ++++
 rtl/pc_unit.sv | 115 +++++++++++
 tb/tb_pc_unit.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared op encodings for the program-counter unit
package pc_pkg;

    localparam int PC_OP_W = 3;

    typedef enum logic [PC_OP_W-1:0] {
        PC_OP_SEQ  = 3'd0,
        PC_OP_BR   = 3'd1,
        PC_OP_JMP  = 3'd2,
        PC_OP_CALL = 3'd3,
        PC_OP_RET  = 3'd4,
        PC_OP_JR   = 3'd5
    } pc_op_e;

endpackage

// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - fetch-side command/status bundle of the program-counter unit
interface pc_unit_if #(
    parameter int DWIDTH = 32,
    parameter int IMM_W  = 17
);
    import pc_pkg::*;

    logic               stall;
    logic [PC_OP_W-1:0] op;
    logic [IMM_W-1:0]   imm;
    logic [DWIDTH-1:0]  target;
    logic [DWIDTH-1:0]  pc_out;
    logic [DWIDTH-1:0]  pc_plus1;
    logic               ras_empty;
    logic               ras_full;
    logic               ras_miss;
    logic               pc_oob;

    modport master (
        output stall, op, imm, target,
        input  pc_out, pc_plus1, ras_empty, ras_full, ras_miss, pc_oob
    );

    modport slave (
        input  stall, op, imm, target,
        output pc_out, pc_plus1, ras_empty, ras_full, ras_miss, pc_oob
    );

endinterface

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack; a push when full overwrites the oldest entry
module pc_ras #(
    parameter int DWIDTH    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DWIDTH-1:0] push_data,
    output logic [DWIDTH-1:0] top_data,
    output logic              empty,
    output logic              full
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [DWIDTH-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]     top;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;

    assign wr_ptr   = top + PW'(1);
    assign top_data = mem[top];
    assign empty    = (count == '0);
    assign full     = (count == CW'(RAS_DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top   <= '0;
            count <= '0;
        end else if (push) begin
            top <= wr_ptr;
            if (!full)
                count <= count + CW'(1);
        end else if (pop && !empty) begin
            top   <= top - PW'(1);
            count <= count - CW'(1);
        end
    end

    // Entry contents are don't-care after reset, so storage carries no reset.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - PC register with next-PC select and return-address stack
// Optional PC_BOUND_CHECK_EN: out-of-range next PC is forced to RESET_VEC and flagged on pc_oob.
module pc_unit
    import pc_pkg::*;
#(
    parameter int               DWIDTH     = 32,
    parameter int               IMM_W      = 17,
    parameter int               RAS_DEPTH  = 4,
    parameter logic [DWIDTH-1:0] RESET_VEC = '0,
    parameter int               IMEM_WORDS = 4096
) (
    input  logic     clk,
    input  logic     rst,
    pc_unit_if.slave bus
);
    logic [DWIDTH-1:0] pc;
    logic [DWIDTH-1:0] pc_inc;
    logic [DWIDTH-1:0] imm_ext;
    logic [DWIDTH-1:0] next_pc;
    logic [DWIDTH-1:0] ras_top;
    logic              push;
    logic              pop;
    logic              miss;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_miss_q;

    assign pc_inc  = pc + DWIDTH'(1);
    assign imm_ext = {{(DWIDTH-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};

    always_comb begin
        next_pc = pc_inc;
        push    = 1'b0;
        pop     = 1'b0;
        miss    = 1'b0;
        case (bus.op)
            PC_OP_BR:  next_pc = pc_inc + imm_ext;
            PC_OP_JMP,
            PC_OP_JR:  next_pc = bus.target;
            PC_OP_CALL: begin
                next_pc = bus.target;
                push    = !bus.stall;
            end
            PC_OP_RET: begin
                if (ras_empty) begin
                    next_pc = bus.target;
                    miss    = 1'b1;
                end else begin
                    next_pc = ras_top;
                    pop     = !bus.stall;
                end
            end
            default:   next_pc = pc_inc;
        endcase
    end

    pc_ras #(
        .DWIDTH    (DWIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

`ifdef PC_BOUND_CHECK_EN
    logic oob;
    logic pc_oob_q;

    assign oob = (next_pc >= DWIDTH'(IMEM_WORDS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_VEC;
            ras_miss_q <= 1'b0;
            pc_oob_q   <= 1'b0;
        end else if (bus.stall) begin
            ras_miss_q <= 1'b0;
            pc_oob_q   <= 1'b0;
        end else begin
            pc         <= oob ? RESET_VEC : next_pc;
            ras_miss_q <= miss;
            pc_oob_q   <= oob;
        end
    end

    assign bus.pc_oob = pc_oob_q;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_VEC;
            ras_miss_q <= 1'b0;
        end else if (bus.stall) begin
            ras_miss_q <= 1'b0;
        end else begin
            pc         <= next_pc;
            ras_miss_q <= miss;
        end
    end

    assign bus.pc_oob = 1'b0;
`endif

    assign bus.pc_out    = pc;
    assign bus.pc_plus1  = pc_inc;
    assign bus.ras_empty = ras_empty;
    assign bus.ras_full  = ras_full;
    assign bus.ras_miss  = ras_miss_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed self-checking bench for pc_unit
module tb_pc_unit;
    import pc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pc_unit_if #(.DWIDTH(32), .IMM_W(17)) bus ();

    pc_unit #(
        .DWIDTH(32), .IMM_W(17), .RAS_DEPTH(4), .RESET_VEC(32'd0), .IMEM_WORDS(4096)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic step(input logic s, input logic [2:0] o, input logic [16:0] i, input logic [31:0] t);
        bus.stall  = s;
        bus.op     = o;
        bus.imm    = i;
        bus.target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] exp_pc;
        #1;
        checks++; if (bus.pc_out !== 32'd0) begin failures++; $display("FAIL reset_pc got=%0h want=0", bus.pc_out); end
        checks++; if (bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0) begin failures++; $display("FAIL reset_ras got=%b%b want=10", bus.ras_empty, bus.ras_full); end
        checks++; if (bus.ras_miss !== 1'b0 || bus.pc_oob !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b want=00", bus.ras_miss, bus.pc_oob); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, PC_OP_SEQ, '0, '0);
            exp_pc = 32'(k);
            checks++; if (bus.pc_out !== exp_pc) begin failures++; $display("FAIL seq_%0d got=%0h want=%0h", k, bus.pc_out, exp_pc); end
        end
        checks++; if (bus.ras_empty !== 1'b1) begin failures++; $display("FAIL seq_ras_empty got=%b want=1", bus.ras_empty); end
        checks++; if (bus.pc_plus1 !== 32'd4) begin failures++; $display("FAIL pc_plus1 got=%0h want=4", bus.pc_plus1); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.pc_out !== 32'd0) begin failures++; $display("FAIL async_reset got=%0h want=0", bus.pc_out); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_branch;
        step(1'b0, PC_OP_JMP, '0, 32'd10);
        checks++; if (bus.pc_out !== 32'd10) begin failures++; $display("FAIL jmp10 got=%0h want=a", bus.pc_out); end
        step(1'b0, PC_OP_BR, 17'h1FFFC, '0);
        checks++; if (bus.pc_out !== 32'd7) begin failures++; $display("FAIL br_neg got=%0h want=7", bus.pc_out); end
        step(1'b0, PC_OP_BR, 17'd5, '0);
        checks++; if (bus.pc_out !== 32'd13) begin failures++; $display("FAIL br_pos got=%0h want=d", bus.pc_out); end
        step(1'b0, PC_OP_JR, '0, 32'd300);
        checks++; if (bus.pc_out !== 32'd300) begin failures++; $display("FAIL jr got=%0h want=12c", bus.pc_out); end
`ifndef PC_BOUND_CHECK_EN
        step(1'b0, PC_OP_JMP, '0, 32'hFFFF_FFFF);
        checks++; if (bus.pc_plus1 !== 32'd0) begin failures++; $display("FAIL plus1_wrap got=%0h want=0", bus.pc_plus1); end
        step(1'b0, PC_OP_SEQ, '0, '0);
        checks++; if (bus.pc_out !== 32'd0) begin failures++; $display("FAIL seq_wrap got=%0h want=0", bus.pc_out); end
`endif
    endtask

    task automatic test_stall;
        step(1'b0, PC_OP_JMP, '0, 32'd40);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, PC_OP_JMP, '0, 32'd100);
            checks++; if (bus.pc_out !== 32'd40) begin failures++; $display("FAIL stall_%0d got=%0h want=28", k, bus.pc_out); end
        end
        step(1'b0, PC_OP_SEQ, '0, 32'd100);
        checks++; if (bus.pc_out !== 32'd41) begin failures++; $display("FAIL stall_release got=%0h want=29", bus.pc_out); end
    endtask

    task automatic test_call_ret;
        logic [31:0] exp_ret [4];
        exp_ret[0] = 32'd401; exp_ret[1] = 32'd301; exp_ret[2] = 32'd201; exp_ret[3] = 32'd101;
        step(1'b0, PC_OP_JMP, '0, 32'd20);
        step(1'b0, PC_OP_CALL, '0, 32'd50);
        checks++; if (bus.pc_out !== 32'd50 || bus.ras_empty !== 1'b0) begin failures++; $display("FAIL call got=%0h/%b want=32/0", bus.pc_out, bus.ras_empty); end
        step(1'b0, PC_OP_RET, '0, 32'd999);
        checks++; if (bus.pc_out !== 32'd21 || bus.ras_empty !== 1'b1) begin failures++; $display("FAIL ret got=%0h/%b want=15/1", bus.pc_out, bus.ras_empty); end
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, PC_OP_CALL, '0, 32'(k * 100));
            if (k == 3) begin
                checks++; if (bus.ras_full !== 1'b0) begin failures++; $display("FAIL ras_not_full got=%b want=0", bus.ras_full); end
            end
        end
        checks++; if (bus.ras_full !== 1'b1 || bus.pc_out !== 32'd500) begin failures++; $display("FAIL ras_full got=%b/%0h want=1/1f4", bus.ras_full, bus.pc_out); end
        for (int k = 0; k < 4; k++) begin
            step(1'b0, PC_OP_RET, '0, 32'd999);
            checks++; if (bus.pc_out !== exp_ret[k]) begin failures++; $display("FAIL nested_ret_%0d got=%0h want=%0h", k, bus.pc_out, exp_ret[k]); end
        end
        checks++; if (bus.ras_empty !== 1'b1 || bus.ras_miss !== 1'b0) begin failures++; $display("FAIL drained got=%b/%b want=1/0", bus.ras_empty, bus.ras_miss); end
        step(1'b0, PC_OP_RET, '0, 32'd7);
        checks++; if (bus.pc_out !== 32'd7 || bus.ras_miss !== 1'b1) begin failures++; $display("FAIL ret_miss got=%0h/%b want=7/1", bus.pc_out, bus.ras_miss); end
        step(1'b0, PC_OP_SEQ, '0, '0);
        checks++; if (bus.pc_out !== 32'd8 || bus.ras_miss !== 1'b0) begin failures++; $display("FAIL miss_pulse got=%0h/%b want=8/0", bus.pc_out, bus.ras_miss); end
        step(1'b0, PC_OP_RET, '0, 32'd9);
        step(1'b1, PC_OP_RET, '0, 32'd9);
        checks++; if (bus.pc_out !== 32'd9 || bus.ras_miss !== 1'b0) begin failures++; $display("FAIL stall_clears_miss got=%0h/%b want=9/0", bus.pc_out, bus.ras_miss); end
    endtask

    task automatic test_bound;
        step(1'b0, PC_OP_JMP, '0, 32'd4095);
        checks++; if (bus.pc_out !== 32'd4095 || bus.pc_oob !== 1'b0) begin failures++; $display("FAIL bound_last got=%0h/%b want=fff/0", bus.pc_out, bus.pc_oob); end
        step(1'b0, PC_OP_JMP, '0, 32'd4096);
`ifdef PC_BOUND_CHECK_EN
        checks++; if (bus.pc_out !== 32'd0 || bus.pc_oob !== 1'b1) begin failures++; $display("FAIL bound_oob got=%0h/%b want=0/1", bus.pc_out, bus.pc_oob); end
        step(1'b0, PC_OP_SEQ, '0, '0);
        checks++; if (bus.pc_out !== 32'd1 || bus.pc_oob !== 1'b0) begin failures++; $display("FAIL bound_pulse got=%0h/%b want=1/0", bus.pc_out, bus.pc_oob); end
`else
        checks++; if (bus.pc_out !== 32'd4096 || bus.pc_oob !== 1'b0) begin failures++; $display("FAIL no_bound got=%0h/%b want=1000/0", bus.pc_out, bus.pc_oob); end
`endif
    endtask

    task automatic test_unused_ops;
        step(1'b0, PC_OP_JMP, '0, 32'd60);
        step(1'b0, 3'd6, 17'd5, 32'd200);
        checks++; if (bus.pc_out !== 32'd61) begin failures++; $display("FAIL op6 got=%0h want=3d", bus.pc_out); end
        step(1'b0, 3'd7, 17'd5, 32'd200);
        checks++; if (bus.pc_out !== 32'd62) begin failures++; $display("FAIL op7 got=%0h want=3e", bus.pc_out); end
    endtask

    initial begin
        bus.stall  = 1'b0;
        bus.op     = PC_OP_SEQ;
        bus.imm    = '0;
        bus.target = '0;
        test_reset();
        test_branch();
        test_stall();
        test_call_ret();
        test_bound();
        test_unused_ops();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
